// File: rtl/fw_loader.sv
// fw_loader: assembles a little-endian byte stream into instruction words, writes them to imem, then verifies a checksum before releasing the CPU
module fw_loader #(
  parameter int FW_LENGTH        = 8,
  parameter int COUNTER_WIDTH    = 12,
  parameter int INSTRUCTON_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        a_reset_n,
  input  logic                        start,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [COUNTER_WIDTH-1:0]    imem_address,
  output logic [INSTRUCTON_WIDTH-1:0] imem_data,
  output logic                        imem_we,
  output logic                        cpu_reset_n,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(FW_LENGTH - 1);
  state_t state, state_nx;
  logic [1:0] byte_cnt;
  logic [COUNTER_WIDTH-1:0] word_cnt;
  logic [7:0] sum;
  logic [23:0] word_lo;
  logic xfer, idle_like;
  assign in_ready    = state == RECV || state == CHECK;
  assign imem_we     = state == WRITE;
  assign busy        = state == RECV || state == WRITE || state == CHECK;
  assign done        = state == DONE;
  assign error       = state == ERROR;
  assign cpu_reset_n = state == DONE;
  assign xfer        = in_valid && in_ready;
  assign idle_like   = state == IDLE || state == DONE || state == ERROR;
  always_ff @(posedge clk)
    state <= !a_reset_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERROR: state_nx = start ? RECV : state;
      RECV:              state_nx = xfer && byte_cnt == 2'd3 ? WRITE : RECV;
      WRITE:             state_nx = word_cnt == LAST ? CHECK : RECV;
      CHECK:             state_nx = xfer ? (in_data == sum ? DONE : ERROR) : CHECK;
      default:           state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!a_reset_n) begin
      byte_cnt     <= '0;
      word_cnt     <= '0;
      sum          <= '0;
      word_lo      <= '0;
      imem_address <= '0;
      imem_data    <= '0;
    end else begin
      if (idle_like && start) begin
        byte_cnt <= '0;
        word_cnt <= '0;
        sum      <= '0;
      end
      if (state == RECV && xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        sum      <= sum + in_data;
        if (byte_cnt != 2'd3)
          word_lo[{byte_cnt, 3'b000} +: 8] <= in_data;
        else begin
          imem_data    <= INSTRUCTON_WIDTH'({in_data, word_lo});
          imem_address <= word_cnt << 2;
        end
      end
      if (state == WRITE)
        word_cnt <= word_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fw_loader.sv
// tb_fw_loader: directed checks of fw_loader with a two-word image
module tb_fw_loader;
  logic clk = 0, a_reset_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, cpu_reset_n, busy, done, error;
  logic [11:0] imem_address;
  logic [31:0] imem_data;
  int checks = 0, errors = 0, nw = 0, rdy_bad = 0, base = 0;
  logic [11:0] wa[64];
  logic [31:0] wd[64];
  logic [7:0] img[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  fw_loader #(.FW_LENGTH(2), .COUNTER_WIDTH(12), .INSTRUCTON_WIDTH(32)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_address(imem_address), .imem_data(imem_data), .imem_we(imem_we),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (imem_we) begin
      if (nw < 64) begin
        wa[nw] = imem_address;
        wd[nw] = imem_data;
      end
      nw++;
      if (in_ready) rdy_bad++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    int n = 0;
    bit acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      in_data = b;
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      acc = in_valid && in_ready;
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic send_range(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) send(img[i], gaps);
  endtask
  task automatic pulse_start;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, nw - base, 2);
    check({tag, "_a0"}, 32'(wa[base]), 32'h000);
    check({tag, "_d0"}, wd[base], 32'h00000013);
    check({tag, "_a1"}, 32'(wa[base + 1]), 32'h004);
    check({tag, "_d1"}, wd[base + 1], 32'h00100093);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rdy"}, 32'(in_ready), 0);
    check({tag, "_we"}, 32'(imem_we), 0);
    check({tag, "_addr"}, 32'(imem_address), 0);
    check({tag, "_data"}, imem_data, 0);
    check({tag, "_cpu"}, 32'(cpu_reset_n), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(error), 0);
  endtask
  task automatic check_done(input string tag);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_err"}, 32'(error), 0);
    check({tag, "_cpu"}, 32'(cpu_reset_n), 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
    end
    @(negedge clk);
    check_reset("rst");
    a_reset_n = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    base = nw;
    pulse_start;
    check("good_rdy_after_start", 32'(in_ready), 1);
    check("good_busy", 32'(busy), 1);
    send_range(0, 3, 0);
    check("good_we_pulse", 32'(imem_we), 1);
    check("good_rdy_in_write", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("good_we_end", 32'(imem_we), 0);
    check("good_rdy_back", 32'(in_ready), 1);
    send_range(4, 7, 0);
    send(8'hB6, 0);
    check_writes("good");
    check_done("good");
    base = nw;
    pulse_start;
    check("bad_cpu_after_start", 32'(cpu_reset_n), 0);
    check("bad_done_after_start", 32'(done), 0);
    send_range(0, 7, 0);
    send(8'hB7, 0);
    check_writes("bad");
    check("bad_err", 32'(error), 1);
    check("bad_done", 32'(done), 0);
    check("bad_cpu", 32'(cpu_reset_n), 0);
    pulse_start;
    check("bad_restart_err", 32'(error), 0);
    check("bad_restart_busy", 32'(busy), 1);
    base = nw;
    send_range(0, 7, 1);
    send(8'hB6, 1);
    check_writes("gap");
    check_done("gap");
    pulse_start;
    send_range(0, 5, 0);
    @(negedge clk) a_reset_n = 0;
    @(negedge clk);
    check_reset("midrst");
    a_reset_n = 1;
    base = nw;
    pulse_start;
    send_range(0, 7, 0);
    send(8'hB6, 0);
    check_writes("after_rst");
    check_done("after_rst");
    base = nw;
    pulse_start;
    send_range(0, 2, 0);
    pulse_start;
    send_range(3, 7, 0);
    send(8'hB6, 0);
    check_writes("ign_start");
    check_done("ign_start");
    check("rdy_during_write", rdy_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fw_loader.md
# fw_loader

Firmware loader that receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into instruction memory starting at address 0. It is the writer side of the instruction store that the CPU fetch path reads. It holds the CPU in reset until exactly FW_LENGTH words plus a trailing checksum byte have been received and verified, then releases it.

## Interface
- FW_LENGTH, 8: number of 32-bit words per image; requires FW_LENGTH*4 <= 2^COUNTER_WIDTH
- COUNTER_WIDTH, 12: width of the instruction-memory byte address, matching the program counter
- INSTRUCTON_WIDTH, 32: instruction word width; fixed at 32

Ports:
- clk  input  1  clock; all logic on rising edge
- a_reset_n  input  1  reset, synchronous and active-low
- start  input  1  one-cycle load request; honoured only in IDLE, DONE or ERROR
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- imem_address  output  COUNTER_WIDTH  byte address of the word being written (word_index*4)
- imem_data  output  INSTRUCTON_WIDTH  assembled word
- imem_we  output  1  one-cycle write strobe
- cpu_reset_n  output  1  CPU reset, active-low; 1 only in DONE
- busy  output  1  in RECV, WRITE or CHECK
- done  output  1  image loaded and checksum matched
- error  output  1  checksum mismatch

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
- Byte transfer occurs when in_valid && in_ready; in_ready = 1 only in RECV and CHECK.
- IDLE: cpu_reset_n=0. start -> RECV, clearing byte_cnt (2 bit), word_cnt, and sum (8 bit).
- RECV: accepted byte k (0..3) is stored into word bits [8k+7:8k], giving little-endian order. Every accepted byte is added to sum mod 256. The transfer with byte_cnt=3 moves to WRITE.
- WRITE: imem_we=1 for exactly one cycle, imem_address = word_cnt<<2 truncated to COUNTER_WIDTH, imem_data = assembled word. Then word_cnt increments. If the new word_cnt == FW_LENGTH go to CHECK, else go to RECV.
- CHECK: the accepted byte is compared with sum (data bytes only). Equal -> DONE, else -> ERROR.
- DONE: done=1, cpu_reset_n=1. Both hold until start, which returns to RECV with cpu_reset_n=0 from the next cycle.
- ERROR: error=1, cpu_reset_n=0. Both hold until start, which goes to RECV and clears error.
- start in RECV/WRITE/CHECK is ignored. in_valid outside RECV/CHECK is ignored, with no data loss claimed.
- imem_address/imem_data are don't-care when imem_we=0, but imem_address/imem_data hold their last values.

## Timing
- Reset (a_reset_n=0 at a rising edge): state IDLE; in_ready=0, imem_we=0, imem_address=0, imem_data=0, cpu_reset_n=0, busy=0, done=0, error=0; all counters and sum = 0.
- Reset mid-load aborts immediately at that edge. Partial words are discarded and already-written words are not undone.
- Outputs are registered or decoded from state only, with no combinational path from in_valid to in_ready.
- start sampled at edge N -> in_ready=1 in cycle N+1.
- 4th byte of a word accepted at edge N -> imem_we=1 during cycle N+1, in_ready=0 that cycle, in_ready=1 again from N+2.
- Minimum 5 cycles per word. Minimum load time FW_LENGTH*5 + 1 cycles after start.
- Checksum accepted at edge N -> done/error and cpu_reset_n valid in cycle N+1.
- Gaps in in_valid stall the FSM indefinitely. There is no timeout.

## Test plan
- Reset: hold a_reset_n=0 for 2 cycles with random inputs -> all outputs 0, cpu_reset_n=0, in_ready=0.
- Good load (FW_LENGTH=2): start, then bytes 13 00 00 00 93 00 10 00, checksum B6 -> writes (addr 0x000, 0x00000013) and (addr 0x004, 0x00100093), one imem_we pulse each; then done=1, cpu_reset_n=1, busy=0.
- Bad checksum: same stream with checksum B7 -> both writes occur, then error=1, done=0, cpu_reset_n=0. A following start clears error and busy=1.
- Backpressure/gaps: same good stream with in_valid randomly low 50% of cycles -> identical writes and done. in_ready=0 in every WRITE cycle.
- Reset mid-operation: a_reset_n=0 after 6 bytes -> IDLE with all outputs at reset values. A new full load then writes from address 0 correctly.
- Start ignored while busy: pulse start after 3 bytes -> no counter reset. Words assemble as if start were absent.
